// File: rtl/display_share_ctrl_if.sv
// Requester / panel bus of the shared 7-segment display arbiter.
// The master side drives requests and values; the slave side drives grants and the panel.
interface display_share_ctrl_if;
  logic        req_a, req_b;
  logic [12:0] value_a, value_b;
  logic        grant_a, grant_b;
  logic [3:0]  Anode;
  logic [6:0]  LED_out;
  logic        busy;

  modport master (
    output req_a, req_b, value_a, value_b,
    input  grant_a, grant_b, Anode, LED_out, busy
  );
  modport slave (
    input  req_a, req_b, value_a, value_b,
    output grant_a, grant_b, Anode, LED_out, busy
  );
endinterface

// File: rtl/display_share_ctrl.sv
// Round-robin sharing of one 4-digit 7-segment panel between two requesters.
// The owner's 13-bit value is converted to BCD serially (double dabble) and then scanned out.
module display_share_ctrl #(
  parameter int REFRESH_BITS = 20,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  display_share_ctrl_if.slave  bus
);

  localparam int DW = $clog2(DWELL_CYCLES);

  typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_t;

  state_t                  state;
  logic [REFRESH_BITS-1:0] scan_cnt;
  logic [DW-1:0]           dwell;
  logic                    last_b;
  logic [12:0]             bin_sh;
  logic [14:0]             bcd_sh;
  logic [3:0]              bit_cnt;
  logic [3:0][3:0]         digits;

  logic [14:0] bcd_adj;
  logic [28:0] dd_next;
  logic        owner_drop, dwell_end, evaluate, win_a, win_b, nxt_idle;
  logic [1:0]  sel;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b0000001;
    endcase
  endfunction

  // The thousands nibble never reaches 5 before the last shift (8191 < 10000),
  // so only the lower three nibbles need the add-3 correction.
  always_comb begin
    bcd_adj = bcd_sh;
    for (int i = 0; i < 3; i++) begin
      if (bcd_sh[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_sh[i*4 +: 4] + 4'd3;
    end
    dd_next = {bcd_adj, bin_sh, 1'b0};
  end

  // One arbiter serves IDLE, dwell expiry and owner drop: a dropped owner has req low,
  // so the tie rule can never hand the display back to it.
  always_comb begin
    owner_drop = (bus.grant_a && !bus.req_a) || (bus.grant_b && !bus.req_b);
    dwell_end  = (dwell == DW'(DWELL_CYCLES - 1));
    evaluate   = (state == IDLE) || ((state == SHOW) && (owner_drop || dwell_end));
    win_a      = bus.req_a && (!bus.req_b || last_b);
    win_b      = bus.req_b && (!bus.req_a || !last_b);
    nxt_idle   = (state == IDLE || state == SHOW) && evaluate && !win_a && !win_b;
  end

  assign sel = scan_cnt[REFRESH_BITS-1 -: 2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      scan_cnt    <= '0;
      dwell       <= '0;
      last_b      <= 1'b1;
      bin_sh      <= '0;
      bcd_sh      <= '0;
      bit_cnt     <= '0;
      digits      <= '0;
      bus.grant_a <= 1'b0;
      bus.grant_b <= 1'b0;
      bus.busy    <= 1'b0;
      bus.Anode   <= 4'hF;
      bus.LED_out <= 7'h7F;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;

      // Panel blanks only in IDLE; CONVERT keeps scanning the previous digits.
      if (nxt_idle) begin
        bus.Anode   <= 4'hF;
        bus.LED_out <= 7'h7F;
      end else begin
        bus.Anode   <= ~(4'b1000 >> sel);
        bus.LED_out <= seg7(digits[~sel]);
      end

      case (state)
        CONVERT: begin
          {bcd_sh, bin_sh} <= dd_next[27:0];
          bit_cnt          <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd12) begin
            digits   <= dd_next[28:13];
            bus.busy <= 1'b0;
            dwell    <= '0;
            state    <= SHOW;
          end
        end
        IDLE, SHOW: begin
          if (evaluate) begin
            dwell       <= '0;
            bus.grant_a <= win_a;
            bus.grant_b <= win_b;
            if (win_a || win_b) begin
              last_b   <= win_b;
              bin_sh   <= win_a ? bus.value_a : bus.value_b;
              bcd_sh   <= '0;
              bit_cnt  <= '0;
              bus.busy <= 1'b1;
              state    <= CONVERT;
            end else begin
              state <= IDLE;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          bus.grant_a <= 1'b0;
          bus.grant_b <= 1'b0;
          bus.busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_share_ctrl.sv
// Directed + random bench for display_share_ctrl against a slice-level reference model.
module tb_display_share_ctrl;
  localparam int RB    = 4;
  localparam int DWELL = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  display_share_ctrl_if bus();
  display_share_ctrl #(.REFRESH_BITS(RB), .DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // model: mode 0=idle 1=convert 2=show; owner/last 0=A 1=B; values as integers
  int m_mode, m_owner, m_last, m_cnt, m_lat, m_shown, m_disp;

  function automatic logic [6:0] seg_ref(input int d);
    logic [6:0] t [10];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
          7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return t[d];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_owner = 0; m_last = 1; m_cnt = 0; m_lat = 0; m_shown = 0; m_disp = 0;
  endtask

  task automatic arbitrate();
    int w;
    w = -1;
    if (bus.req_a && bus.req_b) w = (m_last == 1) ? 0 : 1;
    else if (bus.req_a)         w = 0;
    else if (bus.req_b)         w = 1;
    m_cnt = 0;
    if (w < 0) m_mode = 0;
    else begin
      m_owner = w; m_last = w; m_mode = 1;
      m_lat = (w == 1) ? int'(bus.value_b) : int'(bus.value_a);
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin model_reset(); return; end
    m_disp = m_shown;
    case (m_mode)
      0: arbitrate();
      1: begin
        m_cnt++;
        if (m_cnt == 13) begin m_shown = m_lat; m_mode = 2; m_cnt = 0; end
      end
      default: begin
        if (!((m_owner == 1) ? bus.req_b : bus.req_a) || m_cnt == DWELL - 1) arbitrate();
        else m_cnt++;
      end
    endcase
  endtask

  task automatic check_outputs();
    int place;
    check("grant_a", 32'(bus.grant_a), 32'(m_mode != 0 && m_owner == 0));
    check("grant_b", 32'(bus.grant_b), 32'(m_mode != 0 && m_owner == 1));
    check("grant_onehot", 32'(bus.grant_a & bus.grant_b), 32'd0);
    check("busy", 32'(bus.busy), 32'(m_mode == 1));
    if (m_mode == 0) begin
      check("anode_blank", 32'(bus.Anode), 32'hF);
      check("led_blank", 32'(bus.LED_out), 32'h7F);
    end else begin
      case (bus.Anode)
        4'b0111: place = 1000;
        4'b1011: place = 100;
        4'b1101: place = 10;
        4'b1110: place = 1;
        default: place = 0;
      endcase
      check("anode_valid", 32'(place != 0), 32'd1);
      if (place != 0) check("led_digit", 32'(bus.LED_out), 32'(seg_ref((m_disp / place) % 10)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_mode(input int target, input int limit);
    int k;
    k = 0;
    while (m_mode != target && k < limit) begin step(); k++; end
    n_assert++;
    assert (k < limit) else begin
      n_fail++;
      $error("FAIL wait_mode: observed timeout after %0d cycles expected mode %0d", k, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant_a"}, 32'(bus.grant_a), 32'd0);
    check({tag, "_grant_b"}, 32'(bus.grant_b), 32'd0);
    check({tag, "_busy"},    32'(bus.busy),    32'd0);
    check({tag, "_anode"},   32'(bus.Anode),   32'hF);
    check({tag, "_led"},     32'(bus.LED_out), 32'h7F);
  endtask

  initial begin
    int busy_cnt;
    logic [3:0] seen;
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.value_a = '0; bus.value_b = '0;
    model_reset();

    // reset state
    @(negedge clk);
    check_reset_outputs("reset");
    step(); step();
    rst_n = 1'b1;

    // 1234 on A: grant next edge, 13 busy cycles, digits 1-2-3-4 on the right anodes
    bus.value_a = 13'd1234; bus.req_a = 1'b1;
    step();
    check("first_grant_a", 32'(bus.grant_a), 32'd1);
    busy_cnt = int'(bus.busy);
    for (int i = 0; i < 19; i++) begin step(); busy_cnt += int'(bus.busy); end
    check("busy_len", 32'(busy_cnt), 32'd13);
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus.Anode == 4'b0111 && bus.LED_out == seg_ref(1)) seen[3] = 1'b1;
      if (bus.Anode == 4'b1011 && bus.LED_out == seg_ref(2)) seen[2] = 1'b1;
      if (bus.Anode == 4'b1101 && bus.LED_out == seg_ref(3)) seen[1] = 1'b1;
      if (bus.Anode == 4'b1110 && bus.LED_out == seg_ref(4)) seen[0] = 1'b1;
    end
    check("scan_1234", 32'(seen), 32'hF);

    // owner drops in SHOW with B idle -> blank IDLE on the next edge
    wait_mode(2, 40);
    bus.req_a = 1'b0;
    step();
    check("drop_anode", 32'(bus.Anode), 32'hF);
    check("drop_grants", 32'({bus.grant_a, bus.grant_b}), 32'd0);

    // 8191 then 0 on A across a dwell; old digits stay during the second conversion
    bus.value_a = 13'd8191; bus.req_a = 1'b1;
    wait_mode(2, 40);
    bus.value_a = 13'd0;
    wait_mode(1, 20);
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.Anode == 4'b0111) check("old_thousands", 32'(bus.LED_out), 32'(seg_ref(8)));
    end
    wait_mode(2, 20);
    for (int i = 0; i < 4; i++) begin
      step();
      check("zero_digit", 32'(bus.LED_out), 32'(seg_ref(0)));
    end
    bus.req_a = 1'b0;
    wait_mode(0, 20);

    // both requesting from reset: A, B, A, B
    rst_n = 1'b0; model_reset();
    step();
    rst_n = 1'b1;
    bus.value_a = 13'd5678; bus.value_b = 13'd9012;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_mode(1, 40);
      check("alt_grant_a", 32'(bus.grant_a), 32'(i % 2 == 0));
      wait_mode(2, 40);
    end

    // reset mid-CONVERT: immediate reset outputs, digits cleared afterwards
    bus.req_b = 1'b0; bus.value_a = 13'd4321;
    wait_mode(1, 40);
    for (int i = 0; i < 5; i++) step();
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    model_reset();
    step();
    rst_n = 1'b1;
    step();
    check("digits_cleared", 32'(bus.LED_out), 32'(seg_ref(0)));

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 11) == 0) bus.req_a = ~bus.req_a;
      if ($urandom_range(0, 11) == 0) bus.req_b = ~bus.req_b;
      if ($urandom_range(0, 3) == 0)  bus.value_a = 13'($urandom_range(0, 8191));
      if ($urandom_range(0, 3) == 0)  bus.value_b = 13'($urandom_range(0, 8191));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
